hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
Parametrised hazard/forwarding controller for the in-order RV32I pipeline, evaluated against the instruction in ID.
- Selects the operand source for rs1/rs2 from NUM_FWD downstream stages, the register file, or hard zero.
- Generates load-use and multi-cycle-unit stalls, and multi-cycle flushes for taken branches and exceptions.
- Keeps saturating stall/flush event counters for performance monitoring.

Parameters:
NUM_FWD, 3, number of forwarding stages (index 0 = EX/youngest, NUM_FWD-1 = oldest)
FLUSH_CYCLES, 1, cycles flush_o is held per flush event (>=1)
MC_TIMEOUT, 64, max cycles waiting on multi-cycle unit before abort (>=2)
CNT_W, 16, width of event counters
FSEL_W, $clog2(NUM_FWD+2), derived, forward-select width

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
id_instr_i  in  32  instruction in ID
id_valid_i  in  1  ID holds a valid instruction
stg_rd_addr_i  in  5*NUM_FWD  rd of stage k at bits [5k+4:5k]
stg_rd_wr_en_i  in  NUM_FWD  stage k writes rd
stg_rd_busy_i  in  NUM_FWD  stage k result not yet forwardable (e.g. load in EX)
mc_start_i  in  1  multi-cycle op (mul/div) accepted in EX this cycle
mc_done_i  in  1  multi-cycle result valid
branch_taken_i  in  1  ID redirects PC
exc_i  in  1  exception raised
stall_o  out  1  hold PC/IF/ID, bubble into EX
flush_o  out  1  squash IF/ID
mc_abort_o  out  1  one-cycle pulse aborting multi-cycle unit
timeout_o  out  1  sticky, multi-cycle timeout occurred
fwd_rs1_o  out  FSEL_W  rs1 source select
fwd_rs2_o  out  FSEL_W  rs2 source select
stall_cnt_o  out  CNT_W  cycles with stall_o=1, saturating
flush_cnt_o  out  CNT_W  flush events, saturating

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state RUN, counters 0, timeout_o 0.
  - flush_o=1, stall_o=0, mc_abort_o=0, fwd selects 0.
- Operand use decode:
  - rs1 used by all opcodes except LUI, AUIPC, JAL.
  - rs2 used only by R-type, STORE, BRANCH.
  - Unused operands never cause stalls; their select is 1 (zero).
- Forward select (combinational), per operand:
  - rs==0 gives 1 (zero).
  - Otherwise the lowest k with stg_rd_wr_en_i[k] and rd==rs gives 2+k (youngest wins).
  - No match gives 0 (register file).
- Load-use stall: asserted when id_valid_i, the operand is used, and the winning stage k has stg_rd_busy_i[k]=1. A busy older stage shadowed by a younger non-busy match does not stall. Recomputed every cycle, no latency.
- FSM states RUN, MC_WAIT, FLUSH:
  - RUN: on exc_i go to FLUSH. Else on mc_start_i go to MC_WAIT. Else on branch_taken_i && !stall_o go to FLUSH.
  - MC_WAIT:
    - stall_o=1 while !mc_done_i.
    - On mc_done_i, stall_o=0 in that same cycle and next state is RUN.
    - On exc_i, mc_abort_o=1 for one cycle and next state is FLUSH.
    - On wait counter reaching MC_TIMEOUT: mc_abort_o=1 for one cycle, timeout_o set (sticky until reset), next state RUN.
  - FLUSH: flush_o=1 for FLUSH_CYCLES cycles total, counting the triggering cycle. flush_o is combinationally high in the trigger cycle. stall_o is forced 0. A new exc_i restarts the count. Exit to RUN.
- Flush and stall:
  - flush_o has priority: stall_o=0 whenever flush_o=1.
  - branch_taken_i is ignored while stall_o=1.
- Counters:
  - stall_cnt_o increments each cycle stall_o=1.
  - flush_cnt_o increments once per triggering event, not per held cycle.
  - Both saturate at all-ones.
- Simultaneous events: exc_i beats mc_done_i, mc_start_i and branch_taken_i.

Test Plan:
- Reset then release, ADD x3,x1,x2, no matches -> fwd_rs1_o=0, fwd_rs2_o=0, stall_o=0; flush_o=1 only during reset.
- ADD x5,x1,x1 with stage0 rd=1 wr_en and stage2 rd=1 wr_en -> both selects 2; with stage0 busy -> stall_o=1 and stall_cnt_o increments by 1 per cycle.
- LUI x1 while stage0 is a busy load to rd=1 -> stall_o=0. SW x2,0(x0) with stage1 rd=2 -> fwd_rs2_o=3, fwd_rs1_o=1.
- mc_start_i, then mc_done_i after 5 cycles -> stall_o=1 for 5 cycles, 0 on the done cycle; in a separate run, no done within MC_TIMEOUT=64 -> mc_abort_o pulse, timeout_o=1, state RUN.
- FLUSH_CYCLES=3 with branch_taken_i pulse -> flush_o high 3 cycles, flush_cnt_o=1; branch_taken_i during a load-use stall -> ignored.
- exc_i during MC_WAIT, together with mc_done_i -> mc_abort_o=1, flush_o=1, stall_o=0; async reset mid-FLUSH -> immediate RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for the in-order RV32I pipeline: operand source selection,
// load-use and multi-cycle stalls, timed flushes and saturating perf counters.

module hazard_fwd_sel #(
  parameter int NUM_FWD = 3,
  parameter int FSEL_W  = 3
) (
  input  logic [4:0]           rs,
  input  logic                 used,
  input  logic [5*NUM_FWD-1:0] rd_addr,
  input  logic [NUM_FWD-1:0]   wr_en,
  input  logic [NUM_FWD-1:0]   busy,
  output logic [FSEL_W-1:0]    sel,
  output logic                 hit_busy
);
  // Scan oldest to youngest so the youngest matching stage is assigned last.
  always_comb begin
    sel      = '0;
    hit_busy = 1'b0;
    for (int k = NUM_FWD-1; k >= 0; k--) begin
      if (wr_en[k] && rd_addr[5*k +: 5] == rs) begin
        sel      = FSEL_W'(k + 2);
        hit_busy = busy[k];
      end
    end
    if (!used || rs == 5'd0) begin
      sel      = FSEL_W'(1);
      hit_busy = 1'b0;
    end
  end
endmodule

module hazard_ctrl_unit #(
  parameter int NUM_FWD      = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 16,
  parameter int FSEL_W       = $clog2(NUM_FWD+2)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          id_instr_i,
  input  logic                 id_valid_i,
  input  logic [5*NUM_FWD-1:0] stg_rd_addr_i,
  input  logic [NUM_FWD-1:0]   stg_rd_wr_en_i,
  input  logic [NUM_FWD-1:0]   stg_rd_busy_i,
  input  logic                 mc_start_i,
  input  logic                 mc_done_i,
  input  logic                 branch_taken_i,
  input  logic                 exc_i,
  output logic                 stall_o,
  output logic                 flush_o,
  output logic                 mc_abort_o,
  output logic                 timeout_o,
  output logic [FSEL_W-1:0]    fwd_rs1_o,
  output logic [FSEL_W-1:0]    fwd_rs2_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);
  localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam int FL_W   = $clog2(FLUSH_CYCLES) + 1;

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [FL_W-1:0]   fl_cnt, fl_nxt;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic [6:0]             opcode;
  logic [1:0][4:0]        rs;
  logic [1:0]             used, hit_busy;
  logic [1:0][FSEL_W-1:0] sel;
  logic                   lu_stall, unused_instr;
  logic                   flush_evt, flush_hold, mc_stall, mc_abort, to_hit;

  assign opcode       = id_instr_i[6:0];
  assign used[0]      = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign used[1]      = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign rs           = {id_instr_i[24:20], id_instr_i[19:15]};
  assign unused_instr = ^{id_instr_i[31:25], id_instr_i[14:7]};

  for (genvar i = 0; i < 2; i++) begin : g_op
    hazard_fwd_sel #(.NUM_FWD(NUM_FWD), .FSEL_W(FSEL_W)) u_sel (
      .rs       (rs[i]),
      .used     (used[i]),
      .rd_addr  (stg_rd_addr_i),
      .wr_en    (stg_rd_wr_en_i),
      .busy     (stg_rd_busy_i),
      .sel      (sel[i]),
      .hit_busy (hit_busy[i])
    );
  end

  assign lu_stall = id_valid_i && (|hit_busy);

  // exc beats everything; mc_done beats the timeout in the same cycle.
  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    fl_nxt     = fl_cnt;
    flush_evt  = 1'b0;
    flush_hold = 1'b0;
    mc_stall   = 1'b0;
    mc_abort   = 1'b0;
    to_hit     = 1'b0;
    unique case (state)
      RUN: begin
        if (exc_i) flush_evt = 1'b1;
        else if (mc_start_i) begin
          state_nxt = MC_WAIT;
          wait_nxt  = '0;
        end else if (branch_taken_i && !lu_stall) flush_evt = 1'b1;
      end
      MC_WAIT: begin
        if (exc_i) begin
          flush_evt = 1'b1;
          mc_abort  = 1'b1;
        end else if (mc_done_i) state_nxt = RUN;
        else begin
          mc_stall = 1'b1;
          if (wait_cnt == WAIT_W'(MC_TIMEOUT-1)) begin
            mc_abort  = 1'b1;
            to_hit    = 1'b1;
            state_nxt = RUN;
          end else wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      FLUSH: begin
        flush_hold = 1'b1;
        if (exc_i) flush_evt = 1'b1;
        else if (fl_cnt <= FL_W'(1)) state_nxt = RUN;
        else fl_nxt = fl_cnt - FL_W'(1);
      end
      default: state_nxt = RUN;
    endcase
    // The trigger cycle is the first flush cycle, so FLUSH covers the remainder.
    if (flush_evt) begin
      fl_nxt    = FL_W'(FLUSH_CYCLES-1);
      state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end
  end

  assign flush_o    = !rst_ni || flush_evt || flush_hold;
  assign stall_o    = rst_ni && !flush_o && (lu_stall || mc_stall);
  assign mc_abort_o = rst_ni && mc_abort;
  assign timeout_o  = timeout_q;
  assign fwd_rs1_o  = rst_ni ? sel[0] : '0;
  assign fwd_rs2_o  = rst_ni ? sel[1] : '0;
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= RUN;
      wait_cnt  <= '0;
      fl_cnt    <= '0;
      timeout_q <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      fl_cnt   <= fl_nxt;
      if (to_hit) timeout_q <= 1'b1;
      if (stall_o && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
